// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped LED/PWM and timer peripheral.
package mmio_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_FFF0;
  localparam int          DEF_PWM_BITS  = 8;

  localparam logic [3:0] OFF_DUTY   = 4'h0;
  localparam logic [3:0] OFF_MILLIS = 4'h4;
  localparam logic [3:0] OFF_MICROS = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  typedef logic [DEF_PWM_BITS-1:0] duty_t;

endpackage

// File: rtl/mmio_led_timer_pwm_channel.sv
// One PWM output: latches the shadow duty at the period wrap and drives a registered pin.
module pwm_channel #(
  parameter int PWM_BITS = 8,
  parameter bit INVERT   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] i_shadow_duty,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_wrap,
  input  logic                i_en,
  output logic                o_pin
);

  logic [PWM_BITS-1:0] r_active_duty;
  logic                r_pin;
  logic                w_on;

  // Duty only changes on the wrap edge so a running period is never cut short.
  assign w_on = i_en && (i_pwm_cnt < r_active_duty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active_duty <= '0;
      r_pin         <= INVERT;
    end else begin
      if (i_wrap) r_active_duty <= i_shadow_duty;
      r_pin <= w_on ^ INVERT;
    end
  end

  assign o_pin = r_pin;

endmodule

// File: rtl/mmio_led_timer.sv
// Bus-mapped PWM duty registers for LED/RGB pins plus free-running micros/millis counters.
module mmio_led_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter int          CLK_FREQ_HZ    = 12_000_000,
  parameter int          PWM_BITS       = DEF_PWM_BITS,
  parameter bit          RGB_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        re,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int DIV_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [DIV_W-1:0] US_LAST = DIV_W'(US_DIV - 1);
  localparam logic [9:0]       MS_LAST = 10'd999;

  logic [PWM_BITS-1:0] r_shadow [4];
  logic                r_en;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DIV_W-1:0]    r_us_div;
  logic [9:0]          r_ms_div;
  logic [31:0]         r_micros;
  logic [31:0]         r_millis;
  logic [31:0]         r_rdata;
  logic                r_rvalid;

  logic                w_hit;
  logic [3:0]          w_off;
  logic                w_wr;
  logic                w_rd;
  logic                w_ctrl_wr;
  logic                w_en_next;
  logic                w_wrap;
  logic                w_us_tick;
  logic                w_ms_tick;
  logic [31:0]         w_rdata_mux;
  logic [3:0]          w_pins;
  logic                w_unused;

  assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = {addr[3:2], 2'b00};
  assign w_wr      = we & w_hit;
  assign w_rd      = re & w_hit;
  assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL) && wmask[0];
  // Channels see the incoming EN value so a disable lands on the pins one edge after the write.
  assign w_en_next = w_ctrl_wr ? wdata[0] : r_en;
  assign w_wrap    = (r_pwm_cnt == '1);
  assign w_us_tick = (r_us_div == US_LAST);
  assign w_ms_tick = w_us_tick && (r_ms_div == MS_LAST);
  assign w_unused  = ^{addr[1:0], wdata};

  always_comb begin
    w_rdata_mux = '0;
    case (w_off)
      OFF_DUTY: begin
        for (int i = 0; i < 4; i++) w_rdata_mux[8*i +: PWM_BITS] = r_shadow[i];
      end
      OFF_MILLIS: w_rdata_mux = r_millis;
      OFF_MICROS: w_rdata_mux = r_micros;
      OFF_CTRL:   w_rdata_mux = {31'd0, r_en};
      default:    w_rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      r_en <= 1'b1;
    end else begin
      if (w_wr && (w_off == OFF_DUTY)) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) r_shadow[i] <= wdata[8*i +: PWM_BITS];
        end
      end
      r_en <= w_en_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      r_us_div  <= '0;
      r_ms_div  <= '0;
      r_micros  <= '0;
      r_millis  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_us_div  <= w_us_tick ? '0 : r_us_div + 1'b1;
      if (w_us_tick) begin
        r_micros <= r_micros + 32'd1;
        r_ms_div <= w_ms_tick ? '0 : r_ms_div + 10'd1;
      end
      if (w_ms_tick) r_millis <= r_millis + 32'd1;
    end
  end

  // Read data is captured from pre-edge state, so same-cycle writes and ticks are not visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata_mux;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .INVERT   ((g == 0) ? 1'b0 : RGB_ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .i_shadow_duty (r_shadow[g]),
      .i_pwm_cnt     (r_pwm_cnt),
      .i_wrap        (w_wrap),
      .i_en          (w_en_next),
      .o_pin         (w_pins[g])
    );
  end

  assign hit    = w_hit;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign LED    = w_pins[0];
  assign RGB_R  = w_pins[1];
  assign RGB_G  = w_pins[2];
  assign RGB_B  = w_pins[3];

endmodule

// File: tb/tb_mmio_led_timer.sv
// Directed bench for mmio_led_timer: bus reads/writes, PWM duty counts and timer values.
module tb_mmio_led_timer;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        re;
  logic        hit;
  logic [31:0] rdata;
  logic        rvalid;
  logic        LED;
  logic        RGB_R;
  logic        RGB_G;
  logic        RGB_B;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  mmio_led_timer dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .wmask  (wmask),
    .wdata  (wdata),
    .re     (re),
    .hit    (hit),
    .rdata  (rdata),
    .rvalid (rvalid),
    .LED    (LED),
    .RGB_R  (RGB_R),
    .RGB_G  (RGB_G),
    .RGB_B  (RGB_B)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Driver: one bus cycle starting and ending on a falling edge.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] wm, input logic r,
                     output logic [31:0] d, output logic v);
    addr  = a;
    we    = w;
    wdata = wd;
    wmask = wm;
    re    = r;
    @(posedge clk);
    @(negedge clk);
    d     = rdata;
    v     = rvalid;
    we    = 1'b0;
    re    = 1'b0;
    wmask = 4'h0;
  endtask

  // Count on-cycles per pin (LED high, RGB low) over n falling-edge samples.
  task automatic window(input int n, output int led_on, output int r_on,
                        output int g_on, output int b_on);
    led_on = 0; r_on = 0; g_on = 0; b_on = 0;
    for (int i = 0; i < n; i++) begin
      if (LED === 1'b1)   led_on++;
      if (RGB_R === 1'b0) r_on++;
      if (RGB_G === 1'b0) g_on++;
      if (RGB_B === 1'b0) b_on++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    logic        v;
    logic        prev_r;
    logic        found;
    int          led_on, r_on, g_on, b_on;

    reset = 1'b0;
    addr  = 32'h0;
    we    = 1'b0;
    wmask = 4'h0;
    wdata = 32'h0;
    re    = 1'b0;

    // Reset state and CTRL readback
    do_reset();
    check("rst_led", {31'd0, LED}, 32'd0);
    check("rst_rgb", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("ctrl_rdata", d, 32'h0000_0001);
    check("ctrl_rvalid", {31'd0, v}, 32'd1);
    @(negedge clk);
    check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
    check("rdata_hold", rdata, 32'h0000_0001);

    // Byte-masked duty write with a same-cycle read of the same offset
    bus(BASE, 1'b1, 32'h0000_4000, 4'b0010, 1'b1, d, v);
    check("rw_same_pre_write", d, 32'h0000_0000);
    bus(BASE, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("duty_readback", d, 32'h0000_4000);
    repeat (600) @(negedge clk);
    window(256, led_on, r_on, g_on, b_on);
    check("r_duty40_on", r_on, 32'd64);
    check("led_off", led_on, 32'd0);
    check("g_off", g_on, 32'd0);
    check("b_off", b_on, 32'd0);

    // Find the period start from RGB_R's falling edge (pwm_cnt is then 1)
    found  = 1'b0;
    prev_r = RGB_R;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (prev_r === 1'b1 && RGB_R === 1'b0) found = 1'b1;
      prev_r = RGB_R;
    end
    check("period_found", {31'd0, found}, 32'd1);
    repeat (99) @(negedge clk);
    bus(BASE, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, d, v);
    // Old duties remain for the rest of the period: pwm_cnt 101..255 and 0.
    window(156, led_on, r_on, g_on, b_on);
    check("mid_led_unchanged", led_on, 32'd0);
    check("mid_r_unchanged", r_on, 32'd0);
    window(256, led_on, r_on, g_on, b_on);
    check("full_led_on", led_on, 32'd255);
    check("full_r_on", r_on, 32'd255);
    check("full_g_on", g_on, 32'd255);
    check("full_b_on", b_on, 32'd255);

    // Disable: pins forced off, time keeps running
    bus(BASE + 32'hC, 1'b1, 32'h0, 4'hF, 1'b0, d, v);
    check("en0_led_now", {31'd0, LED}, 32'd0);
    check("en0_rgb_now", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    window(256, led_on, r_on, g_on, b_on);
    check("en0_on_total", led_on + r_on + g_on + b_on, 32'd0);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    repeat (119) @(negedge clk);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 1'b1, d2, v);
    check("micros_delta_120cyc", d2 - d, 32'd10);

    // Misses: no response and no state change
    addr = 32'h0000_1000;
    #1;
    check("hit_miss", {31'd0, hit}, 32'd0);
    addr = BASE + 32'h8;
    #1;
    check("hit_base", {31'd0, hit}, 32'd1);
    @(negedge clk);
    bus(32'h0000_1000, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("miss_rvalid", {31'd0, v}, 32'd0);
    check("miss_rdata_hold", d, d2);
    bus(32'h0000_1000, 1'b1, 32'h0, 4'hF, 1'b0, d, v);
    bus(32'h0000_100C, 1'b1, 32'h1, 4'hF, 1'b0, d, v);
    bus(BASE, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("miss_duty_kept", d, 32'hFFFF_FFFF);
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("miss_ctrl_kept", d, 32'h0);

    // Time counters from a fresh reset: read edges 12000, 12001, 12002
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (11999) @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("millis_pre_tick", d, 32'd0);
    bus(BASE + 32'h4, 1'b1, 32'h1234_5678, 4'hF, 1'b1, d, v);
    check("millis_1", d, 32'd1);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("micros_1000", d, 32'd1000);
    bus(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, d, v);
    check("millis_write_ignored", d, 32'd1);

    // Reset during an accepted read
    addr = BASE + 32'hC;
    re   = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
    check("pre_reset_rvalid", {31'd0, rvalid}, 32'd1);
    check("pre_reset_rdata", rdata, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_rgb", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_led_timer.md
# mmio_led_timer

Memory-mapped peripheral on the core's data bus, directly downstream of `top`'s load/store path and driving the board pins `LED`, `RGB_R`, `RGB_G` and `RGB_B`. It decodes word accesses in a 16-byte window and holds PWM duty registers for the four outputs. It also provides free-running `millis` and `micros` counters that programs read with `lw`. Reads have a fixed one-cycle latency, matching data memory, so the core's load path treats it like a memory bank.

## Interface
- `BASE_ADDR`, 32'hFFFF_FFF0: word-aligned base of the 16-byte window.
- `CLK_FREQ_HZ`, 12_000_000: clock frequency used to derive the µs and ms ticks. Must be a multiple of 1_000_000.
- `PWM_BITS`, 8: width of the duty fields and the PWM counter.
- `RGB_ACTIVE_LOW`, 1: when 1, `RGB_R`, `RGB_G` and `RGB_B` are inverted at the pin. `LED` is always active-high.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `addr` in 32: byte address. Bits [1:0] are ignored.
- `we` in 1: write strobe, qualified by `hit`.
- `wmask` in 4: byte enables for writes.
- `wdata` in 32: write data.
- `re` in 1: read strobe, qualified by `hit`.
- `hit` out 1: combinational; 1 when `addr[31:4] == BASE_ADDR[31:4]`.
- `rdata` out 32: registered read data.
- `rvalid` out 1: 1 for exactly one cycle, the cycle after an accepted read.
- `LED`, `RGB_R`, `RGB_G`, `RGB_B` out 1 each: registered PWM pin outputs.

## Operation
Register map (offset from `BASE_ADDR`):
- 0x0 DUTY, R/W: byte0 = LED, byte1 = R, byte2 = G, byte3 = B. Bytes are written per `wmask`. Only the low `PWM_BITS` of each byte are used.
- 0x4 MILLIS, RO: milliseconds since reset. Writes are ignored.
- 0x8 MICROS, RO: microseconds since reset. Writes are ignored.
- 0xC CTRL, R/W: bit0 = EN (reset 1); bits [31:1] read as 0. With EN=0 all outputs are forced to the off level; PWM and time counters keep running.

PWM behaviour:
- `pwm_cnt` is a free-running `PWM_BITS` counter. A channel is on while `pwm_cnt < active_duty`.
- Duty 0 is always off. Duty 255 is on for 255 of every 256 cycles.
- Written duties go to shadow registers. They are copied to `active_duty` only when `pwm_cnt` wraps to 0, so no period is ever glitched.

Time counters:
- `us_div` counts 0 to `CLK_FREQ_HZ/1e6 - 1`. On reaching the terminal count it emits `us_tick` and MICROS increments.
- `ms_div` counts `us_tick`s 0 to 999. On its terminal count MILLIS increments.
- Both 32-bit counters wrap modulo 2^32 silently.

## Timing
- Write: shadow register or CTRL updates at the first edge with `we & hit`. It reaches the pins at the next PWM wrap plus 1 cycle, because outputs are registered.
- Read: with `re & hit` at edge N, `rdata` and `rvalid` are valid after edge N+1 (1-cycle latency).
- `rdata` holds its last value when there is no read. It is 0 after reset.
- A read and a write to the same offset in the same cycle: the read returns the pre-write value.
- A read of MILLIS or MICROS in a tick cycle returns the pre-increment value.
- `re` or `we` with `hit` = 0: no state change and `rvalid` stays 0.
- Reset values, applied asynchronously and at any time, including mid-read: shadow and active duties 0, `pwm_cnt` 0, dividers 0, MILLIS 0, MICROS 0, CTRL.EN 1, `rdata` 0, `rvalid` 0, `LED` 0, RGB pins at their off level (1 when `RGB_ACTIVE_LOW`=1).
- Reset deassertion is synchronised externally by `top`. This block assumes nothing beyond async assert.

## Structure
- Package `mmio_pkg`:
  - offset constants `OFF_DUTY`, `OFF_MILLIS`, `OFF_MICROS`, `OFF_CTRL`;
  - default `BASE_ADDR`;
  - a `duty_t` typedef sized by `PWM_BITS`.
- Sub-module `pwm_channel`, instantiated ×4:
  - takes shadow duty, `pwm_cnt`, wrap strobe, EN and invert;
  - owns `active_duty` and the registered pin output.
- The top level holds bus decode, the register file, the shared PWM counter and the time dividers.

## Test plan
1. Hold reset low 3 cycles, then release → LED=0, RGB_R/G/B=1, `rvalid`=0. A read of 0xC returns 0x0000_0001 with `rvalid` one cycle later.
2. Write 0x0000_4000 to 0x0 with wmask=4'b0010 → R duty 0x40. After the next wrap, RGB_R is low for exactly 64 of each 256 cycles; other channels stay off.
3. Write DUTY=0xFFFF_FFFF mid-period → pins unchanged until `pwm_cnt` wraps, then on 255/256.
4. Run 12_000 cycles from reset, then read 0x4 and 0x8 → 1 and 1000. Force MICROS to 0xFFFF_FFFF; on the next µs tick it reads 0.
5. Write CTRL=0 with DUTY=0xFFFF_FFFF → all outputs off within 1 cycle. The MICROS count continues.
6. Read with addr=0x0000_1000 (`hit`=0) → `rvalid` stays 0 and no register changes. Assert reset during an accepted read → `rvalid` 0 and `rdata` 0 immediately.
